// File: rtl/hack_alu_seq.sv
// Hack ALU with a handshake wrapper and an optional multi-cycle shift-add
// multiplier. One operation is in flight at a time: IDLE accepts, HOLD
// presents the registered result until the consumer takes it.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operation handshake (ready only in IDLE)
//   x, y                WIDTH-bit operands
//   zx nx zy ny f no    Hack control bits
//   mul                 multiply mode select
//   out_valid/out_ready result handshake
//   out, zr, ng         registered result and flags
//
// Build option: define HACK_ALU_MUL_EN to enable multiply mode (MUL state,
// iteration counter, accumulator). Without it, mul is ignored and every
// operation completes with latency 1.

module hack_alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd2;
`ifdef HACK_ALU_MUL_EN
  localparam logic [1:0] MUL  = 2'd1;
`endif

  logic [1:0] state;

  logic accept;

  logic [WIDTH-1:0] hx;
  logic [WIDTH-1:0] hy;
  logic [WIDTH-1:0] hr;
  logic [WIDTH-1:0] hack_res;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  always_comb begin
    hx = zx ? '0 : x;
    hx = nx ? ~hx : hx;
    hy = zy ? '0 : y;
    hy = ny ? ~hy : hy;
    hr = f ? (hx + hy) : (hx & hy);
    hack_res = no ? ~hr : hr;
  end

`ifdef HACK_ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_nxt;

  // Partial products above bit WIDTH-1 are dropped, which gives the
  // low WIDTH bits of the product for signed and unsigned alike.
  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      out    <= '0;
      zr     <= 1'b1;
      ng     <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (mul) begin
              state  <= MUL;
              cnt    <= '0;
              acc    <= '0;
              mcand  <= x;
              mplier <= y;
            end else begin
              state <= HOLD;
              out   <= hack_res;
              zr    <= (hack_res == '0);
              ng    <= hack_res[WIDTH-1];
            end
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= HOLD;
            out   <= acc_nxt;
            zr    <= (acc_nxt == '0);
            ng    <= acc_nxt[WIDTH-1];
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
`else
  logic unused_mul;
  assign unused_mul = mul;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out   <= '0;
      zr    <= 1'b1;
      ng    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state <= HOLD;
            out   <= hack_res;
            zr    <= (hack_res == '0);
            ng    <= hack_res[WIDTH-1];
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
`endif

endmodule

// File: doc/hack_alu_seq.md
HACK_ALU_SEQ -- requirements
Module: hack_alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits; legal range 2..64.
REQ-002 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port in_valid  input  1  an operation is presented on x, y, zx, nx, zy, ny, f, no and mul.
REQ-005 Port in_ready  output  1  the block accepts the presented operation this cycle.
REQ-006 Port x, y  input  WIDTH each  operands.
REQ-007 Port zx, nx, zy, ny, f, no  input  1 each  Hack ALU control bits.
REQ-008 Port mul  input  1  selects multiply mode; control bits are ignored when mul=1.
REQ-009 Port out_valid  output  1  out, zr and ng hold a completed result.
REQ-010 Port out_ready  input  1  the consumer takes the result this cycle.
REQ-011 Port out  output  WIDTH  registered result.
REQ-012 Port zr, ng  output  1 each  registered flags: zr=(out==0), ng=out[WIDTH-1].

Function
REQ-013 The FSM SHALL have three states: IDLE, MUL, HOLD.
REQ-014 in_ready SHALL equal 1 only in IDLE.
REQ-015 Accept occurs when in_valid=1 and in_ready=1 on a rising edge; the operands and control bits are captured at that edge.
REQ-016 Non-mul accept: on the accept edge, out is loaded with the Hack function (see below), and the FSM moves IDLE->HOLD. out_valid=1 on the next cycle, giving a latency of 1.
REQ-017 Hack function: zx zeroes x; then nx inverts x; zy zeroes y; then ny inverts y; f=1 selects x+y mod 2^WIDTH, f=0 selects x&y; then no inverts the result.
REQ-018 Mul accept: the FSM moves IDLE->MUL and clears an iteration counter and accumulator.
REQ-019 In MUL, one shift-add step is performed per cycle.
REQ-020 On the WIDTH-th MUL edge after accept, out is loaded and the FSM moves to HOLD. out_valid therefore rises WIDTH cycles after accept.
REQ-021 The mul result SHALL be (x*y) mod 2^WIDTH, which is identical for signed and unsigned operands.
REQ-022 In HOLD, out_valid=1 and out, zr and ng are stable.
REQ-023 HOLD->IDLE occurs on an edge with out_ready=1.
REQ-024 A new operation can be accepted no earlier than the cycle after the HOLD exit; there is no same-cycle pass-through.
REQ-025 in_valid while in MUL or HOLD SHALL be ignored, with no state change.
REQ-026 out_ready while out_valid=0 SHALL be ignored.
REQ-027 zr and ng SHALL be computed from the value loaded into out, in the same edge.

Reset
REQ-028 rst=1 SHALL force state=IDLE, out_valid=0, out=0, zr=1, ng=0, counter=0 and accumulator=0 on the next edge.
REQ-029 rst SHALL take priority over every other input, including mid-MUL and in HOLD; any in-flight result is discarded.
REQ-030 While rst=1, in_ready SHALL read 0. After reset deasserts, in_ready=1 from the first cycle.

Configuration
REQ-031 Macro HACK_ALU_MUL_EN defined: mul mode, the MUL state, the counter and the accumulator are present as specified.
REQ-032 Macro HACK_ALU_MUL_EN undefined: the mul input is ignored, every accept follows REQ-016, the MUL state is unreachable/absent, and latency is always 1.

Verification (WIDTH=16 unless noted)
REQ-033 x=0xAAAA, y=0xF0F0, zx..no=000010, mul=0, accept -> next cycle out_valid=1, out=0x9B9A, zr=0, ng=1.
REQ-034 Same operands, controls 010011 (x-y) -> out=0xB9BA, ng=1; controls 111111 -> out=0x0001, zr=0, ng=0; controls 101010 -> out=0x0000, zr=1.
REQ-035 With HACK_ALU_MUL_EN: mul=1, x=3, y=5 -> in_ready=0 for 16 cycles, then out_valid=1, out=0x000F. Also x=0xFFFF, y=0xFFFF -> out=0x0001.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 with new operands -> out stays 0x9B9A, no accept. Raise out_ready -> IDLE, then the new operation is accepted the following cycle.
REQ-037 Assert rst at MUL iteration 7 -> next cycle IDLE, out_valid=0, out=0, zr=1. A subsequent non-mul op is correct.
REQ-038 WIDTH=8 build, x=0xAA, y=0xF0, controls 000010 -> out=0x9A, ng=1. Without HACK_ALU_MUL_EN, mul=1 with controls 000010 -> same result, latency 1.
